// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: two-byte instruction fetch from sync RAM into a prefetch FIFO with redirect.
module instr_fetch_unit #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter int         IBUF_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_req,
  input  logic       mem_gnt,
  output logic       mem_cs,
  output logic       mem_oe,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic       ir_valid,
  input  logic       ir_ready,
  output logic [7:0] ir_pc,
  output logic [7:0] ira,
  output logic [7:0] irb,
  input  logic       redirect,
  input  logic [7:0] redirect_pc
);
  typedef enum logic [1:0] {ISSUE_A, ISSUE_B, CAPTURE_B} state_t;
  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d, hold_q, hold_d;
  logic        agnt_q, agnt_d;
  logic [23:0] buf_q [4];
  logic [23:0] buf_d [4];
  logic [1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [2:0]  cnt_q, cnt_d, occ;
  logic        issue_a, gnt, push, pop;
  logic [7:0]  addr;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'(IBUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction
  // CAPTURE_B doubles as the A-issue of the next instruction, so it counts the in-flight slot
  assign issue_a  = state_q != ISSUE_B;
  assign occ      = cnt_q + 3'(state_q == CAPTURE_B);
  assign addr     = (state_q == ISSUE_A) ? pc_q : (state_q == ISSUE_B) ? pc_q + 8'd1 : pc_q + 8'd2;
  assign mem_req  = !rst && !redirect && (!issue_a || occ < 3'(IBUF_DEPTH));
  assign gnt      = mem_req & mem_gnt;
  assign mem_cs   = gnt;
  assign mem_oe   = gnt;
  assign mem_we   = 1'b0;
  assign mem_addr = rst ? 8'h00 : addr;
  assign ir_valid = cnt_q != 3'd0;
  assign {ir_pc, ira, irb} = buf_q[rd_q];
  assign push     = state_q == CAPTURE_B && !redirect;
  assign pop      = ir_valid && ir_ready;
  always_comb begin
    buf_d   = buf_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q + 3'(push) - 3'(pop);
    pc_d    = push ? pc_q + 8'd2 : pc_q;
    hold_d  = (state_q == ISSUE_B && agnt_q) ? mem_rdata : hold_q;
    agnt_d  = issue_a && gnt;
    state_d = issue_a ? (gnt ? ISSUE_B : ISSUE_A) : (gnt ? CAPTURE_B : ISSUE_B);
    if (push) begin
      buf_d[wr_q] = {pc_q, hold_q, mem_rdata};
      wr_d        = nxt(wr_q);
    end
    if (pop) rd_d = nxt(rd_q);
    if (redirect) begin
      pc_d    = redirect_pc;
      state_d = ISSUE_A;
      agnt_d  = 1'b0;
      cnt_d   = 3'd0;
      wr_d    = 2'd0;
      rd_d    = 2'd0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ISSUE_A;
      pc_q    <= RESET_PC;
      hold_q  <= 8'h00;
      agnt_q  <= 1'b0;
      wr_q    <= 2'd0;
      rd_q    <= 2'd0;
      cnt_q   <= 3'd0;
      for (int i = 0; i < 4; i++) buf_q[i] <= 24'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      agnt_q  <= agnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed fetch scenarios plus a randomized stream scoreboard.
module tb_instr_fetch_unit;
  logic       clk = 0, rst = 1;
  logic       mem_req, mem_gnt, mem_cs, mem_oe, mem_we;
  logic [7:0] mem_addr, mem_rdata;
  logic       ir_valid, ir_ready, redirect;
  logic [7:0] ir_pc, ira, irb, redirect_pc;
  logic [7:0] ram [256];
  int         n_vec = 0, n_err = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_cs(mem_cs),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_pc(ir_pc), .ira(ira), .irb(irb),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_cs) mem_rdata <= ram[mem_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!ir_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, ir_valid, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    logic [7:0] exp_pc, nx;
    logic       exp_flush;
    int         ndeliv;
    mem_gnt = 1; ir_ready = 1; redirect = 0; redirect_pc = 0; mem_rdata = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    ram[8'h00] = 8'h10; ram[8'h01] = 8'h1C; ram[8'h02] = 8'h30; ram[8'h03] = 8'h1D;
    ram[8'hFF] = 8'h90;
    @(negedge clk);
    #1;
    chk("rst_outs", {mem_req, mem_cs, mem_oe, mem_we, mem_addr, ir_valid, ir_pc, ira, irb}, 0);
    // cold start with continuous grant: entries appear on cycles 3 and 5
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("t1_valid%0d", i), ir_valid, (i == 3 || i == 5));
      if (i == 3) chk("t1_e0", {ir_pc, ira, irb}, 24'h00101C);
      if (i == 5) chk("t1_e1", {ir_pc, ira, irb}, 24'h02301D);
      @(negedge clk);
    end
    // stalled consumer fills the buffer and fetch goes quiet
    rst = 1;
    ir_ready = 0;
    @(negedge clk);
    rst = 0;
    repeat (12) @(negedge clk);
    #1;
    chk("t2_valid", ir_valid, 1);
    chk("t2_req", mem_req, 0);
    chk("t2_head", {ir_pc, ira, irb}, 24'h00101C);
    ir_ready = 1;
    @(negedge clk);
    ir_ready = 0;
    #1;
    chk("t2_head2", {ir_pc, ira, irb}, 24'h02301D);
    // redirect to FF exercises address wrap on the operand byte
    @(negedge clk);
    redirect = 1; redirect_pc = 8'hFF;
    #1;
    chk("t5_req", mem_req, 0);
    @(negedge clk);
    redirect = 0;
    #1;
    chk("t5_flush", ir_valid, 0);
    wait_valid("t5_wait");
    chk("t5_e0", {ir_pc, ira, irb}, 24'hFF9010);
    repeat (6) @(negedge clk);
    ir_ready = 1;
    @(negedge clk);
    ir_ready = 0;
    #1;
    chk("t5_e1", {ir_pc, ira, irb}, {8'h01, ram[8'h01], ram[8'h02]});
    // async reset while an operand fetch is outstanding
    ir_ready = 1;
    redirect = 1; redirect_pc = 8'h40;
    @(negedge clk);
    redirect = 0;
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("t6_outs", {mem_req, mem_cs, mem_oe, mem_we, mem_addr, ir_valid, ir_pc, ira, irb}, 0);
    @(negedge clk);
    rst = 0;
    #1;
    wait_valid("t6_wait");
    chk("t6_pc", ir_pc, 8'h00);
    // randomized stream: delivered entries must walk sequential PCs from the last redirect
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ir_ready = 0;
    do_reset();
    exp_pc = 8'h00; exp_flush = 0; ndeliv = 0;
    for (int c = 0; c < 4000; c++) begin
      mem_gnt     = ($urandom % 4) != 0;
      ir_ready    = ($urandom % 3) != 0;
      redirect    = ($urandom % 25) == 0;
      redirect_pc = 8'($urandom);
      #1;
      chk("cs", {mem_cs, mem_oe, mem_we}, {mem_req & mem_gnt, mem_req & mem_gnt, 1'b0});
      if (redirect) chk("rd_req", mem_req, 0);
      if (exp_flush) chk("rd_flush", ir_valid, 0);
      exp_flush = redirect;
      if (ir_valid && ir_ready) begin
        nx = exp_pc + 8'd1;
        chk("pc", ir_pc, exp_pc);
        chk("ira", ira, ram[exp_pc]);
        chk("irb", irb, ram[nx]);
        exp_pc = exp_pc + 8'd2;
        ndeliv++;
      end
      if (redirect) exp_pc = redirect_pc;
      @(negedge clk);
    end
    chk("progress", ndeliv > 300, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
